// File: rtl/board_io_ctrl_pkg.sv
// Shared types for the board I/O housekeeping block.
// LED modes, reset-pulse FSM states and pulse-length width.
package board_io_pkg;

  typedef enum logic [1:0] {
    LED_OFF,
    LED_ON,
    LED_SLOW,
    LED_FAST
  } led_mode_e;

  localparam int RST_LEN_W = 8;

  typedef enum logic {
    IDLE,
    BUSY
  } rst_fsm_e;

endpackage

// File: rtl/board_io_ctrl_if.sv
// Pin-side bundle of the board I/O block.
// master = board / requester side, slave = board_io_ctrl.
interface board_io_ctrl_if #(
  parameter int KEY_WIDTH = 2,
  parameter int NUM_RST   = 3
);

  logic [KEY_WIDTH-1:0] button_in;
  logic [KEY_WIDTH-1:0] button_out;
  logic [KEY_WIDTH-1:0] button_press;
  logic [KEY_WIDTH-1:0] button_long;
  logic [NUM_RST-1:0]   rst_req_in;
  logic [NUM_RST-1:0]   rst_pulse_out;
  logic [1:0]           led_mode;
  logic                 led;

  modport master (
    output button_in,
    output rst_req_in,
    output led_mode,
    input  button_out,
    input  button_press,
    input  button_long,
    input  rst_pulse_out,
    input  led
  );

  modport slave (
    input  button_in,
    input  rst_req_in,
    input  led_mode,
    output button_out,
    output button_press,
    output button_long,
    output rst_pulse_out,
    output led
  );

endinterface

// File: rtl/board_io_ctrl_debounce.sv
// One key: 2-flop synchroniser, debounce counter,
// press pulse and long-press pulse.
module key_debounce_ch #(
  parameter bit ACT_LOW           = 1'b1,
  parameter int DEBOUNCE_CYCLES   = 50000,
  parameter int LONG_PRESS_CYCLES = 100000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_i,
  output logic level_o,
  output logic press_o,
  output logic long_o
);

  localparam logic INACT = ACT_LOW;
  localparam logic ACT   = ~ACT_LOW;
  localparam int   DW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int   HW    = $clog2(LONG_PRESS_CYCLES + 1);

  logic          sync1_q, sync2_q, stable_q;
  logic          press_q, long_q;
  logic [DW-1:0] cnt_q;
  logic [HW-1:0] hold_q;
  logic          flip, held, hold_sat, hold_hit;

  assign flip = (sync2_q != stable_q) &&
                (cnt_q == DW'(DEBOUNCE_CYCLES - 1));
  assign held     = (stable_q == ACT);
  assign hold_sat = (hold_q == HW'(LONG_PRESS_CYCLES - 1));
  assign hold_hit = (HW'(hold_q + 1'b1) ==
                     HW'(LONG_PRESS_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= INACT;
      sync2_q  <= INACT;
      stable_q <= INACT;
      cnt_q    <= '0;
      hold_q   <= '0;
      press_q  <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      if (sync2_q == stable_q || flip) cnt_q <= '0;
      else                             cnt_q <= cnt_q + 1'b1;
      if (flip) stable_q <= sync2_q;
      press_q <= flip && (sync2_q == ACT);
      // hold parks at its top value so long fires once per press
      if (!held)          hold_q <= '0;
      else if (!hold_sat) hold_q <= hold_q + 1'b1;
      long_q <= held && !hold_sat && hold_hit;
    end
  end

  assign level_o = stable_q;
  assign press_o = press_q;
  assign long_o  = long_q;

endmodule

// File: rtl/board_io_ctrl.sv
// Board I/O housekeeping: key debounce, HPS reset-request
// pulse generation and status LED driver.
module board_io_ctrl
  import board_io_pkg::*;
#(
  parameter int    KEY_WIDTH         = 2,
  parameter string POLARITY          = "LOW",
  parameter int    DEBOUNCE_CYCLES   = 50000,
  parameter int    LONG_PRESS_CYCLES = 100000000,
  parameter int    NUM_RST           = 3,
  parameter logic [NUM_RST*RST_LEN_W-1:0]
                   RST_PULSE_LEN     = {8'd32, 8'd2, 8'd6},
  parameter int    BLINK_HALF_PERIOD = 24999999
) (
  input  logic            clk,
  input  logic            reset_n,
  board_io_ctrl_if.slave  io
);

  localparam bit ACT_LOW = (POLARITY == "LOW");
  localparam int PW = $clog2(BLINK_HALF_PERIOD + 1);

  logic [KEY_WIDTH-1:0] lvl, prs, lng;

  for (genvar k = 0; k < KEY_WIDTH; k++) begin : g_key
    key_debounce_ch #(
      .ACT_LOW          (ACT_LOW),
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_key (
      .clk    (clk),
      .reset_n(reset_n),
      .key_i  (io.button_in[k]),
      .level_o(lvl[k]),
      .press_o(prs[k]),
      .long_o (lng[k])
    );
  end

  assign io.button_out   = lvl;
  assign io.button_press = prs;
  assign io.button_long  = lng;

  logic [NUM_RST-1:0] req_q, prev_q, arm_q, pulse;

  // arm_q stays low while a request is held across reset,
  // so only a fresh low->high edge after release triggers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q  <= '0;
      prev_q <= '0;
      arm_q  <= '0;
    end else begin
      req_q  <= io.rst_req_in;
      prev_q <= req_q;
      arm_q  <= arm_q | ~io.rst_req_in;
    end
  end

  for (genvar r = 0; r < NUM_RST; r++) begin : g_rst
    localparam logic [RST_LEN_W-1:0] LEN =
      RST_PULSE_LEN[r*RST_LEN_W +: RST_LEN_W];

    rst_fsm_e             st_q;
    logic [RST_LEN_W-1:0] cnt_q;
    logic                 pulse_q;
    logic                 rise;

    assign rise = req_q[r] & ~prev_q[r] & arm_q[r];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        st_q    <= IDLE;
        cnt_q   <= '0;
        pulse_q <= 1'b0;
      end else begin
        unique case (st_q)
          IDLE: if (rise && LEN != '0) begin
            st_q    <= BUSY;
            cnt_q   <= LEN - 1'b1;
            pulse_q <= 1'b1;
          end
          BUSY: if (cnt_q == '0) begin
            st_q    <= IDLE;
            pulse_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        endcase
      end
    end

    assign pulse[r] = pulse_q;
  end

  assign io.rst_pulse_out = pulse;

  logic [PW-1:0] pre_q;
  logic          slow_q, fast_q, led_q;
  logic          wrap, mid;

  assign wrap = (pre_q == PW'(BLINK_HALF_PERIOD));
  assign mid  = (pre_q == PW'(BLINK_HALF_PERIOD >> 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q  <= '0;
      slow_q <= 1'b0;
      fast_q <= 1'b0;
      led_q  <= 1'b0;
    end else begin
      pre_q <= wrap ? '0 : pre_q + 1'b1;
      if (wrap)        slow_q <= ~slow_q;
      if (wrap || mid) fast_q <= ~fast_q;
      unique case (led_mode_e'(io.led_mode))
        LED_OFF:  led_q <= 1'b0;
        LED_ON:   led_q <= 1'b1;
        LED_SLOW: led_q <= slow_q;
        LED_FAST: led_q <= fast_q;
      endcase
    end
  end

  assign io.led = led_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Event scoreboard bench for board_io_ctrl: stimulus queues
// expected output edges, a negedge monitor matches them.
module tb_board_io_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  board_io_ctrl_if #(.KEY_WIDTH(2), .NUM_RST(3)) io1 ();
  board_io_ctrl_if #(.KEY_WIDTH(2), .NUM_RST(3)) io2 ();

  board_io_ctrl #(
    .KEY_WIDTH(2), .POLARITY("LOW"),
    .DEBOUNCE_CYCLES(8), .LONG_PRESS_CYCLES(32),
    .NUM_RST(3), .RST_PULSE_LEN({8'd32, 8'd2, 8'd6}),
    .BLINK_HALF_PERIOD(15)
  ) dut (.clk(clk), .reset_n(reset_n), .io(io1.slave));

  board_io_ctrl #(
    .KEY_WIDTH(2), .POLARITY("LOW"),
    .DEBOUNCE_CYCLES(8), .LONG_PRESS_CYCLES(32),
    .NUM_RST(3), .RST_PULSE_LEN({8'd32, 8'd0, 8'd6}),
    .BLINK_HALF_PERIOD(15)
  ) dut2 (.clk(clk), .reset_n(reset_n), .io(io2.slave));

  assign io2.button_in  = io1.button_in;
  assign io2.rst_req_in = io1.rst_req_in;
  assign io2.led_mode   = io1.led_mode;

  typedef struct {
    int id;
    int val;
    int t;
  } ev_t;

  ev_t exq[$];
  int  cyc = 0;
  int  rel = 0;
  int  checks = 0;
  int  failures = 0;

  always @(posedge clk) cyc = cyc + 1;

  // ids: 0-1 out, 2-3 press, 4-5 long, 6-8 rst, 9 led, 10-12 dut2 rst
  function automatic logic [12:0] obs_vec();
    return {io2.rst_pulse_out, io1.led, io1.rst_pulse_out,
            io1.button_long, io1.button_press, io1.button_out};
  endfunction

  function automatic void push_ev(int id, int val, int t);
    int i = 0;
    while (i < exq.size() &&
           (exq[i].t < t || (exq[i].t == t && exq[i].id < id)))
      i++;
    exq.insert(i, '{id, val, t});
  endfunction

  function automatic void exp_pulse(int id, int len, int c);
    push_ev(id, 1, c + 2);
    push_ev(id, 0, c + 2 + len);
  endfunction

  function automatic int led_model(int mode, int n);
    case (mode)
      0: return 0;
      1: return 1;
      2: return ((n - 1) / 16) % 2;
      default: return ((n - 1) / 8) % 2;
    endcase
  endfunction

  int led_prev = 0;

  function automatic void led_window(int mode, int c, int len);
    for (int t = c + 1; t <= c + len; t++) begin
      int v = led_model(mode, t - rel);
      if (v != led_prev) push_ev(9, v, t);
      led_prev = v;
    end
  endfunction

  logic [12:0] prev_obs, cur;
  bit started = 0;
  ev_t e;

  always @(negedge clk) begin
    cur = obs_vec();
    if (!started) begin
      started = 1;
      checks++;
      if (cur !== 13'h003) begin
        failures++;
        $display("FAIL reset_state got=%b want=%b",
                 cur, 13'h003);
      end
    end else begin
      while (exq.size() > 0 && exq[0].t < cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_event id=%0d val=%0d t=%0d now=%0d",
                 exq[0].id, exq[0].val, exq[0].t, cyc);
        void'(exq.pop_front());
      end
      for (int i = 0; i < 13; i++) begin
        if (cur[i] !== prev_obs[i]) begin
          checks++;
          if (exq.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event id=%0d val=%b t=%0d",
                     i, cur[i], cyc);
          end else begin
            e = exq.pop_front();
            if (e.id != i || e.val != int'(cur[i]) ||
                e.t != cyc) begin
              failures++;
              $display("FAIL event got id=%0d val=%b t=%0d want id=%0d val=%0d t=%0d",
                       i, cur[i], cyc, e.id, e.val, e.t);
            end
          end
        end
      end
    end
    prev_obs = cur;
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int c;

  initial begin
    io1.button_in  = 2'b11;
    io1.rst_req_in = 3'b000;
    io1.led_mode   = 2'd0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    rel = cyc;
    tick(5);

    // short glitch on key0: no events
    io1.button_in = 2'b10;
    tick(5);
    io1.button_in = 2'b11;
    tick(20);

    // key0 long hold: press, long, release
    c = cyc;
    io1.button_in = 2'b10;
    push_ev(0, 0, c + 10);
    push_ev(2, 1, c + 10);
    push_ev(2, 0, c + 11);
    push_ev(4, 1, c + 41);
    push_ev(4, 0, c + 42);
    tick(40);
    c = cyc;
    io1.button_in = 2'b11;
    push_ev(0, 1, c + 10);
    tick(30);

    // key1 short hold: press only
    c = cyc;
    io1.button_in = 2'b01;
    push_ev(1, 0, c + 10);
    push_ev(3, 1, c + 10);
    push_ev(3, 0, c + 11);
    tick(20);
    c = cyc;
    io1.button_in = 2'b11;
    push_ev(1, 1, c + 10);
    tick(20);

    // all reset channels together, retrigger while busy
    c = cyc;
    io1.rst_req_in = 3'b111;
    exp_pulse(6, 6, c);
    exp_pulse(7, 2, c);
    exp_pulse(8, 32, c);
    exp_pulse(10, 6, c);
    exp_pulse(12, 32, c);
    tick(10);
    io1.rst_req_in = 3'b011;
    tick(5);
    io1.rst_req_in = 3'b111;
    tick(25);
    io1.rst_req_in = 3'b011;
    tick(5);
    c = cyc;
    io1.rst_req_in = 3'b111;
    exp_pulse(8, 32, c);
    exp_pulse(12, 32, c);
    tick(40);
    io1.rst_req_in = 3'b000;
    tick(5);

    // ch1 toggles: dut2 ch1 has length 0
    for (int k = 0; k < 3; k++) begin
      c = cyc;
      io1.rst_req_in = 3'b010;
      exp_pulse(7, 2, c);
      tick(3);
      io1.rst_req_in = 3'b000;
      tick(4);
    end

    // LED modes
    c = cyc;
    io1.led_mode = 2'd2;
    led_window(2, c, 70);
    tick(70);
    c = cyc;
    io1.led_mode = 2'd3;
    led_window(3, c, 40);
    tick(40);
    c = cyc;
    io1.led_mode = 2'd1;
    led_window(1, c, 5);
    tick(5);
    c = cyc;
    io1.led_mode = 2'd0;
    led_window(0, c, 5);
    tick(5);

    // reset in the middle of a pulse, request held across it
    c = cyc;
    io1.rst_req_in = 3'b100;
    push_ev(8, 1, c + 2);
    push_ev(12, 1, c + 2);
    tick(10);
    push_ev(8, 0, cyc);
    push_ev(12, 0, cyc);
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    rel = cyc;
    tick(40);
    io1.rst_req_in = 3'b000;
    tick(3);
    c = cyc;
    io1.rst_req_in = 3'b100;
    exp_pulse(8, 32, c);
    exp_pulse(12, 32, c);
    tick(40);
    io1.rst_req_in = 3'b000;
    tick(5);

    while (exq.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL leftover_event id=%0d val=%0d t=%0d",
               exq[0].id, exq[0].val, exq[0].t);
      void'(exq.pop_front());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
